// File: rtl/vx_ti_trav_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vx_ti_trav_ctrl
// Purpose  : BVH traversal sequencer for the ray-tracing unit. It takes one
//            ray's root node and walks the BVH depth-first. For every visited
//            node it issues a fetch. Far children go onto the external
//            traversal stack and are popped back when a subtree finishes.
//            Leaves are handed to primitive intersection, and a completion
//            token follows the last leaf.
// Ports    : clk, reset (async, active-low)
//            ray_*       : ray intake handshake + root index
//            mem_req_*   : node fetch request
//            mem_rsp_*   : node fetch response (leaf flag, child hits/indices)
//            leaf_*      : leaf hand-off to intersection
//            stk_*       : push/pop port of the traversal stack (sole driver)
//            done_*      : completion token with node count / overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module vx_ti_trav_ctrl #(
  parameter int NODE_BITS = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 ray_valid,
  output logic                 ray_ready,
  input  logic [NODE_BITS-1:0] ray_root,

  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [NODE_BITS-1:0] mem_req_node,

  input  logic                 mem_rsp_valid,
  output logic                 mem_rsp_ready,
  input  logic                 mem_rsp_leaf,
  input  logic [1:0]           mem_rsp_hit,
  input  logic [NODE_BITS-1:0] mem_rsp_left,
  input  logic [NODE_BITS-1:0] mem_rsp_right,
  input  logic                 mem_rsp_near_right,

  output logic                 leaf_valid,
  input  logic                 leaf_ready,
  output logic [NODE_BITS-1:0] leaf_node,

  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [NODE_BITS-1:0] stk_data_in,
  input  logic [NODE_BITS-1:0] stk_data_out,
  input  logic                 stk_empty,
  input  logic                 stk_full,

  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [CNT_BITS-1:0]  done_nodes,
  output logic                 done_overflow
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LEAF  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_BITS-1:0] c_cnt_max = '1;

  state_t               r_state, w_state_nxt;
  logic [NODE_BITS-1:0] r_cur,   w_cur_nxt;
  logic [CNT_BITS-1:0]  r_cnt,   w_cnt_nxt;
  logic                 r_ovf,   w_ovf_nxt;

  // Near/far child selection from the response currently on the bus.
  logic [NODE_BITS-1:0] w_near;
  logic [NODE_BITS-1:0] w_far;

  assign w_near = mem_rsp_near_right ? mem_rsp_right : mem_rsp_left;
  assign w_far  = mem_rsp_near_right ? mem_rsp_left  : mem_rsp_right;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_cnt_nxt     = r_cnt;
    w_ovf_nxt     = r_ovf;

    ray_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    leaf_valid    = 1'b0;
    done_valid    = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;

    // Payloads come straight from registers so they stay stable while the
    // matching valid is held.
    mem_req_node  = r_cur;
    leaf_node     = r_cur;
    done_nodes    = r_cnt;
    done_overflow = r_ovf;
    stk_data_in   = w_far;

    case (r_state)
      S_IDLE: begin
        ray_ready = 1'b1;
        if (ray_valid) begin
          w_cur_nxt   = ray_root;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          // Saturating count so that a huge traversal never reports a
          // deceptively small number.
          if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + CNT_BITS'(1);
          end
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          if (mem_rsp_leaf) begin
            w_state_nxt = S_LEAF;
          end else begin
            case (mem_rsp_hit)
              2'b11: begin
                // Descend into the nearer child; the farther one is saved
                // for later unless the stack has no room, in which case
                // the subtree is lost and flagged.
                w_cur_nxt   = w_near;
                stk_push    = !stk_full;
                if (stk_full) begin
                  w_ovf_nxt = 1'b1;
                end
                w_state_nxt = S_FETCH;
              end
              2'b01: begin
                w_cur_nxt   = mem_rsp_left;
                w_state_nxt = S_FETCH;
              end
              2'b10: begin
                w_cur_nxt   = mem_rsp_right;
                w_state_nxt = S_FETCH;
              end
              default: begin
                w_state_nxt = S_NEXT;
              end
            endcase
          end
        end
      end

      S_LEAF: begin
        leaf_valid = 1'b1;
        if (leaf_ready) begin
          w_state_nxt = S_NEXT;
        end
      end

      S_NEXT: begin
        // The stack top is consumed in the same cycle the pop is issued.
        if (stk_empty) begin
          w_state_nxt = S_DONE;
        end else begin
          stk_pop     = 1'b1;
          w_cur_nxt   = stk_data_out;
          w_state_nxt = S_FETCH;
        end
      end

      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_ti_trav_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_ti_trav_ctrl
// Purpose  : Directed testbench for vx_ti_trav_ctrl. The bench plays the
//            memory, intersection and completion consumers, and holds a small
//            stack model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_ti_trav_ctrl;

  localparam int NB = 32;
  localparam int CB = 3;

  logic          clk;
  logic          reset;
  logic          ray_valid, ray_ready;
  logic [NB-1:0] ray_root;
  logic          mem_req_valid, mem_req_ready;
  logic [NB-1:0] mem_req_node;
  logic          mem_rsp_valid, mem_rsp_ready, mem_rsp_leaf, mem_rsp_near_right;
  logic [1:0]    mem_rsp_hit;
  logic [NB-1:0] mem_rsp_left, mem_rsp_right;
  logic          leaf_valid, leaf_ready;
  logic [NB-1:0] leaf_node;
  logic          stk_push, stk_pop, stk_empty, stk_full;
  logic [NB-1:0] stk_data_in, stk_data_out;
  logic          done_valid, done_ready, done_overflow;
  logic [CB-1:0] done_nodes;

  int checks = 0;
  int errors = 0;

  vx_ti_trav_ctrl #(.NODE_BITS(NB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_root(ray_root),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_node(mem_req_node),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_leaf(mem_rsp_leaf), .mem_rsp_hit(mem_rsp_hit),
    .mem_rsp_left(mem_rsp_left), .mem_rsp_right(mem_rsp_right),
    .mem_rsp_near_right(mem_rsp_near_right),
    .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .leaf_node(leaf_node),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_nodes(done_nodes), .done_overflow(done_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack model: 8 entries, full can also be forced.
  logic [NB-1:0] stk_mem [0:7];
  logic [3:0]    sp;
  logic          force_full;
  int            push_cnt, pop_cnt;

  assign stk_empty    = (sp == 4'd0);
  assign stk_full     = force_full || (sp == 4'd8);
  assign stk_data_out = (sp == 4'd0) ? '0 : stk_mem[3'(sp - 4'd1)];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= 4'd0;
    end else begin
      if (stk_push) begin
        stk_mem[sp[2:0]] <= stk_data_in;
        sp               <= sp + 4'd1;
        push_cnt         <= push_cnt + 1;
      end
      if (stk_pop) begin
        sp      <= sp - 4'd1;
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_ray(input logic [NB-1:0] root);
    @(negedge clk);
    chk("ray_ready", ray_ready, 1);
    ray_valid = 1'b1;
    ray_root  = root;
    @(posedge clk);
    #1 ray_valid = 1'b0;
    @(negedge clk);
    chk("req_after_ray", mem_req_valid, 1);
  endtask

  task automatic req(input logic [NB-1:0] node, input int stall);
    int n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", mem_req_valid, 1);
    chk("req_node", mem_req_node, node);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("req_hold_valid", mem_req_valid, 1);
      chk("req_hold_node", mem_req_node, node);
      chk("req_hold_state", mem_rsp_ready, 0);
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
  endtask

  task automatic rsp(input logic leaf, input logic [1:0] hit, input logic [NB-1:0] l,
                     input logic [NB-1:0] r, input logic nr, input logic exp_push);
    @(negedge clk);
    mem_rsp_valid      = 1'b1;
    mem_rsp_leaf       = leaf;
    mem_rsp_hit        = hit;
    mem_rsp_left       = l;
    mem_rsp_right      = r;
    mem_rsp_near_right = nr;
    #1;
    chk("rsp_ready", mem_rsp_ready, 1);
    chk("stk_push", stk_push, exp_push);
    chk("stk_pop_in_wait", stk_pop, 0);
    if (exp_push) chk("push_data", stk_data_in, nr ? l : r);
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0;
  endtask

  task automatic leaf(input logic [NB-1:0] node, input int stall);
    int n = 0;
    @(negedge clk);
    while (!leaf_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("leaf_valid", leaf_valid, 1);
    chk("leaf_node", leaf_node, node);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("leaf_hold_valid", leaf_valid, 1);
      chk("leaf_hold_node", leaf_node, node);
    end
    leaf_ready = 1'b1;
    @(posedge clk);
    #1 leaf_ready = 1'b0;
  endtask

  task automatic done(input logic [CB-1:0] nodes, input logic ovf);
    int n = 0;
    @(negedge clk);
    while (!done_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_valid", done_valid, 1);
    chk("done_nodes", done_nodes, nodes);
    chk("done_overflow", done_overflow, ovf);
    chk("no_leaf_at_done", leaf_valid, 0);
    done_ready = 1'b1;
    @(posedge clk);
    #1 done_ready = 1'b0;
  endtask

  int p0, q0;

  initial begin
    reset = 1'b0;
    ray_valid = 0; ray_root = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_leaf = 0; mem_rsp_hit = 2'b00;
    mem_rsp_left = '0; mem_rsp_right = '0; mem_rsp_near_right = 0;
    leaf_ready = 0; done_ready = 0; force_full = 0;
    push_cnt = 0; pop_cnt = 0;

    // Reset state
    #1;
    chk("rst_ray_ready", ray_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_leaf_valid", leaf_valid, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Leaf root
    send_ray(32'd5);
    req(32'd5, 0);
    rsp(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    leaf(32'd5, 0);
    done(3'd1, 1'b0);

    // Two-level tree
    p0 = push_cnt; q0 = pop_cnt;
    send_ray(32'd1);
    req(32'd1, 0);
    rsp(1'b0, 2'b11, 32'd2, 32'd3, 1'b0, 1'b1);
    req(32'd2, 0);
    rsp(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    leaf(32'd2, 0);
    req(32'd3, 0);
    rsp(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    leaf(32'd3, 0);
    done(3'd3, 1'b0);
    chk("two_lvl_pushes", push_cnt - p0, 1);
    chk("two_lvl_pops", pop_cnt - q0, 1);

    // Miss at root
    p0 = push_cnt; q0 = pop_cnt;
    send_ray(32'd1);
    req(32'd1, 0);
    rsp(1'b0, 2'b00, 32'd2, 32'd3, 1'b0, 1'b0);
    done(3'd1, 1'b0);
    chk("miss_pushes", push_cnt - p0, 0);
    chk("miss_pops", pop_cnt - q0, 0);

    // Stack overflow: far child dropped
    force_full = 1'b1;
    p0 = push_cnt;
    send_ray(32'd1);
    req(32'd1, 0);
    rsp(1'b0, 2'b11, 32'd6, 32'd7, 1'b1, 1'b0);
    req(32'd7, 0);
    rsp(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    leaf(32'd7, 0);
    done(3'd2, 1'b1);
    chk("ovf_pushes", push_cnt - p0, 0);
    force_full = 1'b0;

    // Backpressure on request and leaf
    send_ray(32'd1);
    req(32'd1, 5);
    rsp(1'b0, 2'b11, 32'd2, 32'd3, 1'b0, 1'b1);
    req(32'd2, 0);
    rsp(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    leaf(32'd2, 3);
    req(32'd3, 0);
    rsp(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    leaf(32'd3, 0);
    done(3'd3, 1'b0);

    // Single-child chain of 9 nodes: counter saturates at 7
    send_ray(32'd10);
    for (int i = 0; i < 8; i++) begin
      req(32'(10 + i), 0);
      if (i % 2 == 1) rsp(1'b0, 2'b10, 32'd99, 32'(11 + i), 1'b0, 1'b0);
      else            rsp(1'b0, 2'b01, 32'(11 + i), 32'd99, 1'b0, 1'b0);
    end
    req(32'd18, 0);
    rsp(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    leaf(32'd18, 0);
    done(3'd7, 1'b0);

    // Reset while waiting on a response
    send_ray(32'd1);
    req(32'd1, 0);
    @(negedge clk);
    chk("pre_rst_wait", mem_rsp_ready, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req_valid", mem_req_valid, 0);
    chk("mid_rst_rsp_ready", mem_rsp_ready, 0);
    chk("mid_rst_leaf_valid", leaf_valid, 0);
    chk("mid_rst_done_valid", done_valid, 0);
    chk("mid_rst_ray_ready", ray_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    send_ray(32'd5);
    req(32'd5, 0);
    rsp(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    leaf(32'd5, 0);
    done(3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_ti_trav_ctrl.md
# vx_ti_trav_ctrl

BVH traversal sequencer for the ray-tracing (ti) unit. It accepts one ray's root node index and walks the BVH depth-first. It issues a node fetch for each visited node and pushes far children onto the adjacent traversal stack, popping them when a subtree is finished. Leaf nodes go downstream to primitive intersection, and a completion token follows the last leaf. It is the sole driver of the traversal stack's push/pop port.

## Interface
- NODE_BITS, 32, node index width; equals the stack entry width
- CNT_BITS, 16, width of the visited-node counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- ray_valid / ray_ready  in / out  1  ray handshake
- ray_root  in  NODE_BITS  root node index
- mem_req_valid / mem_req_ready  out / in  1  node fetch request handshake
- mem_req_node  out  NODE_BITS  node to fetch
- mem_rsp_valid / mem_rsp_ready  in / out  1  node response handshake
- mem_rsp_leaf  in  1  fetched node is a leaf
- mem_rsp_hit  in  2  child box hits: [0] = left, [1] = right
- mem_rsp_left, mem_rsp_right  in  NODE_BITS  child indices
- mem_rsp_near_right  in  1  right child is nearer
- leaf_valid / leaf_ready  out / in  1  leaf handshake to intersection
- leaf_node  out  NODE_BITS  leaf index
- stk_push, stk_pop  out  1  stack controls; never both 1 in the same cycle
- stk_data_in  out  NODE_BITS  entry to push
- stk_data_out  in  NODE_BITS  top of stack; valid whenever !stk_empty
- stk_empty, stk_full  in  1  stack status
- done_valid / done_ready  out / in  1  traversal-complete handshake
- done_nodes  out  CNT_BITS  nodes fetched for this ray; saturates at all-ones
- done_overflow  out  1  one or more far children were dropped because the stack was full

## Operation
- FSM states: IDLE, FETCH, WAIT, LEAF, NEXT, DONE. Registers: cur (node index), cnt, ovf.
- IDLE: ray_ready = 1. On ray_valid: cur <= ray_root, cnt <= 0, ovf <= 0, go to FETCH.
- FETCH: mem_req_valid = 1, mem_req_node = cur. On mem_req_ready: cnt <= sat(cnt + 1), go to WAIT.
- WAIT: mem_rsp_ready = 1. On mem_rsp_valid:
  - leaf: go to LEAF.
  - hit = 11: near = mem_rsp_near_right ? right : left, far = the other child. cur <= near. stk_push = !stk_full with stk_data_in = far, both combinational in the accept cycle. If stk_full: no push, ovf <= 1. Go to FETCH.
  - hit = 01 or 10: cur <= the hit child, go to FETCH.
  - hit = 00: go to NEXT.
- LEAF: leaf_valid = 1, leaf_node = cur. On leaf_ready: go to NEXT.
- NEXT: if stk_empty, go to DONE. Otherwise stk_pop = 1, cur <= stk_data_out, go to FETCH.
- DONE: done_valid = 1, with done_nodes = cnt and done_overflow = ovf. On done_ready: go to IDLE.
- All valid outputs and their payloads stay stable until the matching ready is seen. The block never withdraws a valid.
- stk_push and stk_pop are single-cycle pulses. The stack shares the same reset.

## Timing
- Reset (reset = 0): state = IDLE and cur, cnt, ovf = 0. Every valid, stk_push and stk_pop is 0. ray_ready reads 1; upstream must not handshake while reset is 0.
- A reset mid-traversal aborts the ray immediately. Nothing is emitted for it, and an outstanding memory response is the memory side's responsibility to flush.
- Ray accepted at cycle t: mem_req_valid goes high at t+1.
- Each node costs at least 2 cycles: FETCH for 1 cycle, then WAIT for 1 cycle when the response is already valid.
- A leaf adds at least 1 cycle in LEAF. Each pop adds 1 cycle in NEXT.
- The pop happens in NEXT, and stk_data_out is sampled in that same cycle.
- A push happens only in the WAIT accept cycle, so a push and a pop never coincide.
- cnt saturates at 2^CNT_BITS - 1 and does not wrap.

## Test plan
- Leaf root: ray_root = 5, response leaf = 1 → one request for node 5, leaf_node = 5, done_nodes = 1, done_overflow = 0.
- Two-level tree: root 1 with hit = 11, left = 2, right = 3, near_right = 0; nodes 2 and 3 are leaves → requests 1, 2, 3 in order, a single push of 3, leaves 2 then 3, done_nodes = 3.
- Miss: root 1 with hit = 00 → no leaf, no push or pop, done_nodes = 1.
- Overflow: stk_full forced to 1, root hit = 11, near = right = 7 → no stk_push, requests 1 then 7, done_overflow = 1.
- Backpressure: mem_req_ready held low for 5 cycles and leaf_ready held low for 3 cycles → valid and payload held constant, state does not advance, final results match the unstalled run.
- Reset asserted during WAIT → all valids 0 asynchronously. After release, ray_ready = 1, and a new ray with a leaf root completes with done_nodes = 1.
